// File: rtl/cpwm8c_pkg.sv
// Shared sizes and enumerations for the eight-channel carrier PWM core.
package cpwm8c_pkg;

   localparam int DEF_CW  = 16;
   localparam int DEF_NCH = 8;
   localparam int DEF_DTW = 8;

   typedef enum logic {MODE_SAW, MODE_TRI} cpwm_mode_t;
   typedef enum logic {DIR_UP, DIR_DOWN} cpwm_dir_t;

endpackage

// File: rtl/cpwm8c_deadtime.sv
// One complementary output pair with dead-time insertion between side changes.
module cpwm8c_deadtime
   import cpwm8c_pkg::*;
#(
   parameter int DTW = DEF_DTW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           run,
   input  logic           raw,
   input  logic           mask,
   input  logic [DTW-1:0] dt,
   output logic           h,
   output logic           l
);

   logic [1:0]     st;
   logic [1:0]     prev;
   logic [DTW-1:0] dcnt;
   logic           h_new;
   logic           l_new;

   // Mask is part of the tracked state so an unmask always costs a full dead time
   assign st    = {mask, raw & mask};
   assign h_new = st[1] & st[0];
   assign l_new = st[1] & ~st[0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= '0;
         dcnt <= '0;
         h    <= 1'b0;
         l    <= 1'b0;
      end else if (!run) begin
         prev <= '0;
         dcnt <= '0;
         h    <= 1'b0;
         l    <= 1'b0;
      end else begin
         prev <= st;
         if (st != prev) begin
            dcnt <= dt;
            h    <= (dt == '0) && h_new;
            l    <= (dt == '0) && l_new;
         end else if (dcnt != '0) begin
            dcnt <= dcnt - DTW'(1);
            h    <= (dcnt == DTW'(1)) && h_new;
            l    <= (dcnt == DTW'(1)) && l_new;
         end else begin
            h <= h_new;
            l <= l_new;
         end
      end
   end

endmodule

// File: rtl/cpwm8c_core.sv
// Shared sawtooth/triangle carrier with shadowed configuration, feeding
// NCH compare channels with complementary dead-time outputs.
module cpwm8c_core
   import cpwm8c_pkg::*;
#(
   parameter int CW  = DEF_CW,
   parameter int NCH = DEF_NCH,
   parameter int DTW = DEF_DTW
) (
   input  logic              ACLK,
   input  logic              ARESET,
   input  logic              en_i,
   input  logic              mode_i,
   input  logic [CW-1:0]     period_i,
   input  logic [NCH*CW-1:0] cmp_i,
   input  logic [DTW-1:0]    dt_i,
   input  logic [NCH-1:0]    mask_i,
   output logic [NCH-1:0]    pwm_h_o,
   output logic [NCH-1:0]    pwm_l_o,
   output logic [CW-1:0]     cnt_o,
   output logic              zero_o,
   output logic              peak_o
);

   logic              running;
   logic [CW-1:0]     cnt;
   logic [CW-1:0]     cnt_next;
   cpwm_dir_t         dir;
   cpwm_dir_t         dir_next;
   logic              wrap;
   logic [CW-1:0]     act_p;
   cpwm_mode_t        act_mode;
   logic [DTW-1:0]    act_dt;
   logic [NCH*CW-1:0] act_cmp;
   logic              dt_run;

   // Next carrier value; a peak of 0 or 1 folds straight back to 0 going up
   always_comb begin
      cnt_next = '0;
      dir_next = DIR_UP;
      if (act_mode == MODE_SAW) begin
         if (cnt < act_p) cnt_next = cnt + CW'(1);
      end else if (dir == DIR_UP) begin
         if (cnt < act_p) begin
            cnt_next = cnt + CW'(1);
         end else if (cnt > CW'(1)) begin
            cnt_next = cnt - CW'(1);
            dir_next = DIR_DOWN;
         end
      end else begin
         if (cnt > CW'(1)) begin
            cnt_next = cnt - CW'(1);
            dir_next = DIR_DOWN;
         end
      end
   end

   assign wrap = (cnt_next == '0);

   // Configuration is only sampled at a wrap or on the first running edge
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         running  <= 1'b0;
         cnt      <= '0;
         dir      <= DIR_UP;
         act_p    <= '0;
         act_mode <= MODE_SAW;
         act_dt   <= '0;
         act_cmp  <= '0;
      end else if (!en_i) begin
         running <= 1'b0;
         cnt     <= '0;
         dir     <= DIR_UP;
      end else if (!running || wrap) begin
         running  <= 1'b1;
         cnt      <= running ? cnt_next : '0;
         dir      <= DIR_UP;
         act_p    <= period_i;
         act_mode <= cpwm_mode_t'(mode_i);
         act_dt   <= dt_i;
         act_cmp  <= cmp_i;
      end else begin
         cnt <= cnt_next;
         dir <= dir_next;
      end
   end

   assign cnt_o  = cnt;
   assign zero_o = running && (cnt == '0);
   assign peak_o = running && (cnt == act_p);
   assign dt_run = en_i && running;

   for (genvar n = 0; n < NCH; n++) begin : g_ch
      cpwm8c_deadtime #(.DTW(DTW)) u_dt (
         .clk  (ACLK),
         .rst  (ARESET),
         .run  (dt_run),
         .raw  (cnt < act_cmp[n*CW +: CW]),
         .mask (mask_i[n]),
         .dt   (act_dt),
         .h    (pwm_h_o[n]),
         .l    (pwm_l_o[n])
      );
   end

endmodule
